// File: rtl/spi_shift_datapath.sv
// SPI mode-0 bit datapath: TX load/shift onto MOSI, MISO sampling, byte completion and byte counting.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first shifting; default is MSB-first.
module spi_shift_datapath #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pos_edge_i,
  input  logic              neg_edge_i,
  input  logic              en_load_i,
  input  logic              en_shift_tx_i,
  input  logic              en_shift_rx_i,
  input  logic [1:0]        mux_all_01_sel_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              clr_cnt_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              byte_done_o,
  output logic [2:0]        bit_cnt_o,
  output logic [CNT_W-1:0]  rx_byte_cnt_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_shift_nxt;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              busy_q, busy_d;
  logic              rx_valid_q, rx_valid_d;
  logic              byte_done_q, byte_done_d;
  logic              mosi_q, mosi_d;
  logic              rise_qual, fall_qual, last_bit;

  // A rising tick wins over a (theoretically impossible) simultaneous falling tick.
  assign rise_qual = pos_edge_i & busy_q & (en_shift_rx_i | en_shift_tx_i);
  assign fall_qual = neg_edge_i & ~pos_edge_i & en_shift_tx_i & busy_q;
  assign last_bit  = rise_qual & (bit_cnt_q == 3'(DATA_W - 1));

`ifdef SPI_LSB_FIRST_EN
  assign rx_shift_nxt = {miso_i, rx_shift_q[DATA_W-1:1]};
`else
  assign rx_shift_nxt = {rx_shift_q[DATA_W-2:0], miso_i};
`endif

  always_comb begin
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    byte_done_d = 1'b0;

    if (en_load_i) begin
      case (mux_all_01_sel_i)
        2'b01:   tx_shift_d = '0;
        2'b10:   tx_shift_d = '1;
        default: tx_shift_d = tx_data_i;
      endcase
      rx_shift_d = '0;
      bit_cnt_d  = 3'd0;
      busy_d     = 1'b1;
    end else if (rise_qual) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (en_shift_rx_i) begin
        rx_shift_d = rx_shift_nxt;
      end
      if (last_bit) begin
        bit_cnt_d   = 3'd0;
        busy_d      = 1'b0;
        byte_done_d = 1'b1;
        byte_cnt_d  = byte_cnt_q + 1'b1;
        if (en_shift_rx_i) begin
          rx_data_d  = rx_shift_nxt;
          rx_valid_d = 1'b1;
        end
      end
    end else if (fall_qual) begin
`ifdef SPI_LSB_FIRST_EN
      tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
`else
      tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
`endif
    end

    if (clr_cnt_i) begin
      byte_cnt_d = '0;
    end

`ifdef SPI_LSB_FIRST_EN
    mosi_d = tx_shift_d[0];
`else
    mosi_d = tx_shift_d[DATA_W-1];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      byte_done_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      busy_q      <= busy_d;
      rx_valid_q  <= rx_valid_d;
      byte_done_q <= byte_done_d;
      mosi_q      <= mosi_d;
    end
  end

  assign mosi_o        = mosi_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign byte_done_o   = byte_done_q;
  assign bit_cnt_o     = bit_cnt_q;
  assign rx_byte_cnt_o = byte_cnt_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_spi_shift_datapath.sv
// Scoreboard bench for spi_shift_datapath: expected RX bytes queued at stimulus, checked on rx_valid_o.
module tb_spi_shift_datapath;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       pos_edge_i = 1'b0, neg_edge_i = 1'b0, en_load_i = 1'b0;
  logic       en_shift_tx_i = 1'b0, en_shift_rx_i = 1'b0, clr_cnt_i = 1'b0;
  logic [1:0] mux_all_01_sel_i = 2'b00;
  logic [7:0] tx_data_i = 8'h00;
  logic       miso_i, miso_drv = 1'b0, loop_en = 1'b0;
  logic       mosi_o, rx_valid_o, byte_done_o, busy_o;
  logic [7:0] rx_data_o;
  logic [2:0] bit_cnt_o;
  logic [9:0] rx_byte_cnt_o;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_done = 0;
  logic [7:0] exp_q[$];

  always #50 clk_i = ~clk_i;
  assign miso_i = loop_en ? mosi_o : miso_drv;

  spi_shift_datapath #(.DATA_W(8), .CNT_W(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pos_edge_i(pos_edge_i), .neg_edge_i(neg_edge_i),
    .en_load_i(en_load_i), .en_shift_tx_i(en_shift_tx_i), .en_shift_rx_i(en_shift_rx_i),
    .mux_all_01_sel_i(mux_all_01_sel_i), .tx_data_i(tx_data_i), .clr_cnt_i(clr_cnt_i),
    .miso_i(miso_i), .mosi_o(mosi_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .byte_done_o(byte_done_o), .bit_cnt_o(bit_cnt_o), .rx_byte_cnt_o(rx_byte_cnt_o),
    .busy_o(busy_o)
  );

  // Output monitor: every rx_valid_o pulse pops one expected byte.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (byte_done_o) n_done++;
      if (rx_valid_o) begin
        logic [7:0] e;
        n_valid++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_scoreboard: unexpected rx_valid_o, rx_data_o=%h", rx_data_o);
        end else begin
          e = exp_q.pop_front();
          if (rx_data_o !== e) begin
            bad++;
            $display("FAIL rx_data: got %h expected %h", rx_data_o, e);
          end
        end
      end
    end
  end

  function automatic int bit_idx(input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  task automatic do_load(input logic [7:0] d, input logic [1:0] sel);
    tx_data_i = d;
    mux_all_01_sel_i = sel;
    en_load_i = 1'b1;
    @(negedge clk_i);
    en_load_i = 1'b0;
  endtask

  // Eight SCLK periods; mosi_o checked before every rising tick, bit_cnt_o too.
  task automatic run_byte(input logic [7:0] mosi_exp, input logic rx_en,
                          input logic [7:0] rx_exp, input logic clr_last);
    if (rx_en) exp_q.push_back(rx_exp);
    en_shift_tx_i = 1'b1;
    en_shift_rx_i = rx_en;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mosi_o !== mosi_exp[bit_idx(i)]) begin
        bad++;
        $display("FAIL mosi_bit%0d: got %b expected %b", i, mosi_o, mosi_exp[bit_idx(i)]);
      end
      total++;
      if (bit_cnt_o !== 3'(i)) begin
        bad++;
        $display("FAIL bit_cnt%0d: got %0d expected %0d", i, bit_cnt_o, i);
      end
      pos_edge_i = 1'b1;
      if (i == 7) clr_cnt_i = clr_last;
      @(negedge clk_i);
      pos_edge_i = 1'b0;
      clr_cnt_i = 1'b0;
      @(negedge clk_i);
      neg_edge_i = 1'b1;
      @(negedge clk_i);
      neg_edge_i = 1'b0;
      @(negedge clk_i);
    end
    total++;
    if (busy_o !== 1'b0 || bit_cnt_o !== 3'd0) begin
      bad++;
      $display("FAIL byte_end_idle: busy=%b bit_cnt=%0d expected 0/0", busy_o, bit_cnt_o);
    end
  endtask

  task automatic check_cnt(input string name, input logic [9:0] e);
    total++;
    if (rx_byte_cnt_o !== e) begin
      bad++;
      $display("FAIL %s: rx_byte_cnt_o=%0d expected %0d", name, rx_byte_cnt_o, e);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({mosi_o, rx_data_o, rx_valid_o, byte_done_o, bit_cnt_o, rx_byte_cnt_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL %s: mosi=%b rx=%h vld=%b done=%b bc=%0d cnt=%0d busy=%b expected all 0",
               name, mosi_o, rx_data_o, rx_valid_o, byte_done_o, bit_cnt_o, rx_byte_cnt_o, busy_o);
    end
  endtask

  task automatic check_pulses(input string name, input int v0, input int d0, input int dv, input int dd);
    total++;
    if (n_valid - v0 != dv || n_done - d0 != dd) begin
      bad++;
      $display("FAIL %s: rx_valid pulses=%0d byte_done pulses=%0d expected %0d/%0d",
               name, n_valid - v0, n_done - d0, dv, dd);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset_state");
    rst_i = 1'b1;
    @(negedge clk_i);
    pos_edge_i = 1'b1; en_shift_tx_i = 1'b1; en_shift_rx_i = 1'b1;
    @(negedge clk_i);
    pos_edge_i = 1'b0;
    check_all_zero("idle_tick_ignored");
  endtask

  task automatic test_loopback(input logic [7:0] d, input string name);
    int v0 = n_valid, d0 = n_done;
    loop_en = 1'b1;
    do_load(d, 2'b00);
    run_byte(d, 1'b1, d, 1'b0);
    loop_en = 1'b0;
    check_pulses(name, v0, d0, 1, 1);
  endtask

  task automatic test_sel_fill();
    int v0 = n_valid, d0 = n_done;
    miso_drv = 1'b0;
    do_load(8'h5A, 2'b10);
    run_byte(8'hFF, 1'b1, 8'h00, 1'b0);
    check_cnt("cnt_after_sel10", 10'd2);
    miso_drv = 1'b1;
    do_load(8'h5A, 2'b01);
    run_byte(8'h00, 1'b1, 8'hFF, 1'b0);
    check_cnt("cnt_after_sel01", 10'd3);
    check_pulses("sel_fill_pulses", v0, d0, 2, 2);
  endtask

  task automatic test_tx_only();
    logic [7:0] pat [5] = '{8'h3C, 8'h81, 8'h00, 8'hFF, 8'h5A};
    int v0, d0;
    clr_cnt_i = 1'b1;
    @(negedge clk_i);
    clr_cnt_i = 1'b0;
    check_cnt("cnt_clear", 10'd0);
    v0 = n_valid; d0 = n_done;
    for (int b = 0; b < 5; b++) begin
      miso_drv = 1'($urandom_range(0, 1));
      do_load(pat[b], 2'b00);
      run_byte(pat[b], 1'b0, 8'h00, 1'b0);
    end
    check_cnt("cnt_tx_only_5", 10'd5);
    check_pulses("tx_only_pulses", v0, d0, 0, 5);
    total++;
    if (rx_data_o !== 8'hFF) begin
      bad++;
      $display("FAIL rx_data_hold: got %h expected ff", rx_data_o);
    end
    clr_cnt_i = 1'b1;
    @(negedge clk_i);
    clr_cnt_i = 1'b0;
    for (int b = 0; b < 5; b++) begin
      do_load(pat[b], 2'b11);
      run_byte(pat[b], 1'b0, 8'h00, b == 4);
      if (b == 3) check_cnt("cnt_before_clr", 10'd4);
    end
    check_cnt("clr_wins_increment", 10'd0);
  endtask

  task automatic test_load_wins();
    miso_drv = 1'b0;
    do_load(8'h00, 2'b00);
    en_shift_tx_i = 1'b1; en_shift_rx_i = 1'b1;
    pos_edge_i = 1'b1;
    @(negedge clk_i);
    pos_edge_i = 1'b0;
    @(negedge clk_i);
    neg_edge_i = 1'b1; en_load_i = 1'b1; tx_data_i = 8'h81; mux_all_01_sel_i = 2'b00;
    @(negedge clk_i);
    neg_edge_i = 1'b0; en_load_i = 1'b0;
    total++;
    if (mosi_o !== 1'b1 || bit_cnt_o !== 3'd0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL load_wins: mosi=%b bc=%0d busy=%b expected 1/0/1", mosi_o, bit_cnt_o, busy_o);
    end
    run_byte(8'h81, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_byte();
    int d0 = n_done;
    do_load(8'hC3, 2'b00);
    en_shift_tx_i = 1'b1; en_shift_rx_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pos_edge_i = 1'b1; @(negedge clk_i); pos_edge_i = 1'b0; @(negedge clk_i);
      neg_edge_i = 1'b1; @(negedge clk_i); neg_edge_i = 1'b0; @(negedge clk_i);
    end
    total++;
    if (bit_cnt_o !== 3'd3) begin
      bad++;
      $display("FAIL mid_byte_cnt: got %0d expected 3", bit_cnt_o);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pos_edge_i = (i % 2 == 0);
      @(negedge clk_i);
    end
    pos_edge_i = 1'b0;
    check_all_zero("reset_mid_byte");
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_all_zero("after_reset_release");
    check_pulses("reset_no_done", n_valid, d0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_loopback(8'hA5, "loopback_a5");
    check_cnt("cnt_after_a5", 10'd1);
    test_sel_fill();
    test_tx_only();
    test_load_wins();
    test_loopback(8'h01, "loopback_01");
    test_reset_mid_byte();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expected bytes never arrived, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_shift_datapath.md
Name: spi_shift_datapath

Overview:
- Bit-level SPI datapath (mode 0: CPOL=0, CPHA=0) directly downstream of module_fsm_spi.
- Consumes the FSM's en_load / en_shift_tx / en_shift_rx / mux_all_01_sel strobes and the reloj_divisor pos_edge / neg_edge ticks.
- Serialises one 8-bit TX word onto MOSI, deserialises MISO into an RX byte, and reports byte completion so the FSM can count words against n_rx_end.

Parameters:
- DATA_W, 8, shift word width in bits
- CNT_W, 10, width of the received-byte counter (matches n_rx_end_o)

Ports:
- clk_i  in  1  system clock, 10 MHz
- rst_i  in  1  synchronous reset, active-low
- pos_edge_i  in  1  one-cycle tick, SCLK rising edge
- neg_edge_i  in  1  one-cycle tick, SCLK falling edge
- en_load_i  in  1  load TX shift register, one-cycle pulse
- en_shift_tx_i  in  1  enable MOSI shifting
- en_shift_rx_i  in  1  enable MISO sampling
- mux_all_01_sel_i  in  2  load source select
- tx_data_i  in  DATA_W  word from TX data register
- clr_cnt_i  in  1  clear byte counter, start of transaction
- miso_i  in  1  serial input
- mosi_o  out  1  serial output
- rx_data_o  out  DATA_W  last completed RX byte
- rx_valid_o  out  1  one-cycle pulse, rx_data_o updated
- byte_done_o  out  1  one-cycle pulse, 8th bit sampled
- bit_cnt_o  out  3  bits sampled in current byte
- rx_byte_cnt_o  out  CNT_W  completed bytes since clr_cnt_i
- busy_o  out  1  byte in progress

Behaviour:
- Reset: rst_i sampled low on a clk_i edge clears all registers. Resulting outputs: mosi_o=0, rx_data_o=0, rx_valid_o=0, byte_done_o=0, bit_cnt_o=0, rx_byte_cnt_o=0, busy_o=0.
- Reset mid-byte aborts the byte with no byte_done_o pulse.
- Load: en_load_i=1 writes tx_shift on the next edge.
  - sel 00: tx_data_i
  - sel 01: all 0s
  - sel 10: all 1s
  - sel 11: tx_data_i
  - Load also sets bit_cnt=0 and busy_o=1.
- mosi_o is registered and equals the current output bit of tx_shift (MSB by default). The first bit is valid the cycle after the load, before the first rising SCLK edge.
- TX shift: on a cycle with neg_edge_i & en_shift_tx_i & busy_o, tx_shift shifts one position and fills with 0.
  - If en_load_i and neg_edge_i occur in the same cycle, load wins.
- RX sample: a qualified rising edge is pos_edge_i & busy_o & (en_shift_rx_i | en_shift_tx_i).
  - On each qualified rising edge, bit_cnt increments.
  - rx_shift takes {rx_shift[DATA_W-2:0], miso_i} only when en_shift_rx_i=1.
- Byte end: on the qualified rising edge with bit_cnt==7:
  - bit_cnt wraps to 0 and busy_o drops.
  - byte_done_o pulses for 1 cycle, in the cycle after the edge.
  - If en_shift_rx_i=1: rx_data_o <= the completed word, including the current miso_i bit, and rx_valid_o pulses in that same cycle.
  - rx_byte_cnt increments, wrapping at 2^CNT_W-1 -> 0.
- Ticks ignored while busy_o=0. The trailing falling edge after the 8th bit is a no-op.
- clr_cnt_i clears rx_byte_cnt. If it coincides with an increment, clear wins and the result is 0.
- Latency: the last rising tick reaches rx_data_o/rx_valid_o in 1 clk_i cycle.
- Simultaneous pos_edge_i and neg_edge_i cannot occur. If both are asserted anyway, only the pos_edge_i action is taken.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined:
  - mosi_o is driven from tx_shift[0] and TX shifts right.
  - RX fills from the MSB ({miso_i, rx_shift[DATA_W-1:1]}), so the first received bit lands in bit 0.
- Undefined: MSB-first, as described above.
- Counters, handshakes and latency are identical in both builds.

Test Plan:
- Reset: hold rst_i=0 for 5 cycles mid-byte (bit_cnt=3). Expect all outputs 0 and no byte_done_o pulse.
- Loopback (miso_i tied to mosi_o), tx_data_i=0xA5, sel=00, both enables on, 8 SCLK periods. Expect mosi_o sequence 1,0,1,0,0,1,0,1; rx_data_o=0xA5; exactly one rx_valid_o and one byte_done_o pulse; rx_byte_cnt_o=1.
- sel=10 with miso_i=0. Expect mosi_o=1 for all 8 bits and rx_data_o=0x00.
- sel=01 with miso_i=1. Expect mosi_o=0 for all bits and rx_data_o=0xFF.
- TX-only (en_shift_rx_i=0), 5 consecutive bytes.
  - Expect rx_valid_o never pulses, rx_data_o holds its previous value, and byte_done_o pulses 5 times.
  - Expect rx_byte_cnt_o=5; assert clr_cnt_i on the 5th increment cycle and expect 0.
- SPI_LSB_FIRST_EN build, loopback 0x01. Expect mosi_o first bit=1 then 0s, and rx_data_o=0x01.
